// File: rtl/nabp_mapper_lut_scheduler.sv
// Angle sweep scheduler for the NABP mapper LUT.
// Walks first..last in steps, issuing one lookup per cycle. It only issues
// while it has credit: lookups in flight plus queued entries must stay below
// the skid FIFO depth. LUT results are tagged and queued, then handed to the
// mapper over a valid/ready handshake.
module nabp_mapper_lut_scheduler #(
    parameter int ANGLE_WIDTH = 8,
    parameter int PART_WIDTH  = 16,
    parameter int BASE_WIDTH  = 16,
    parameter int LUT_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hs_start,
    input  logic [ANGLE_WIDTH-1:0] hs_angle_first,
    input  logic [ANGLE_WIDTH-1:0] hs_angle_last,
    input  logic [ANGLE_WIDTH-1:0] hs_angle_step,
    output logic                   hs_busy,
    output logic                   hs_done,
    output logic                   hs_error,
    output logic [ANGLE_WIDTH-1:0] lut_angle,
    input  logic [PART_WIDTH-1:0]  lut_accu_part,
    input  logic [BASE_WIDTH-1:0]  lut_accu_base,
    output logic                   mp_valid,
    input  logic                   mp_ready,
    output logic                   mp_last,
    output logic [ANGLE_WIDTH-1:0] mp_angle,
    output logic [PART_WIDTH-1:0]  mp_accu_part,
    output logic [BASE_WIDTH-1:0]  mp_accu_base
);

    localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int CRW  = $clog2(FIFO_DEPTH + LUT_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e                   state_q, state_d;
    logic [ANGLE_WIDTH-1:0]   last_q, step_q, angle_q;
    logic                     error_q;

    logic [LUT_LATENCY-1:0]   tag_valid_q;
    logic [ANGLE_WIDTH-1:0]   tag_angle_q [LUT_LATENCY];
    logic                     tag_final_q [LUT_LATENCY];

    logic [ANGLE_WIDTH-1:0]   fifo_angle_q [FIFO_DEPTH];
    logic [PART_WIDTH-1:0]    fifo_part_q  [FIFO_DEPTH];
    logic [BASE_WIDTH-1:0]    fifo_base_q  [FIFO_DEPTH];
    logic                     fifo_last_q  [FIFO_DEPTH];
    logic [PTRW-1:0]          rd_ptr_q, wr_ptr_q;
    logic [CNTW-1:0]          count_q;

    logic                     cfg_bad, is_final, credit, issue, push, pop;
    logic [ANGLE_WIDTH:0]     next_sum;
    logic [CRW-1:0]           occupancy;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Configuration check, next-angle arithmetic and the credit/issue decision.
    // The extra sum bit catches wrap-around, so an overflowing step also ends the sweep.
    always_comb begin
        cfg_bad  = (hs_angle_step == '0) || (hs_angle_first > hs_angle_last) ||
                   (32'(hs_angle_last) > 32'd179);
        next_sum = {1'b0, angle_q} + {1'b0, step_q};
        is_final = next_sum > {1'b0, last_q};
        occupancy = CRW'(count_q);
        for (int i = 0; i < LUT_LATENCY; i++) begin
            occupancy = occupancy + CRW'(tag_valid_q[i]);
        end
        credit = occupancy < CRW'(FIFO_DEPTH);
        issue  = (state_q == ISSUE) && credit;
        push   = tag_valid_q[LUT_LATENCY-1];
        pop    = (count_q != '0) && mp_ready;
    end

    // Sweep state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic. A rejected configuration goes straight to DONE without issuing anything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs_start) state_d = cfg_bad ? DONE : ISSUE;
            ISSUE:   if (issue && is_final) state_d = DRAIN;
            DRAIN:   if (pop && fifo_last_q[rd_ptr_q]) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the sweep configuration on a start request and advance the angle on each issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q  <= '0;
            step_q  <= '0;
            angle_q <= '0;
            error_q <= 1'b0;
        end else if (state_q == IDLE && hs_start) begin
            last_q  <= hs_angle_last;
            step_q  <= hs_angle_step;
            angle_q <= hs_angle_first;
            error_q <= cfg_bad;
        end else if (issue && !is_final) begin
            angle_q <= next_sum[ANGLE_WIDTH-1:0];
        end
    end

    // Valid tags travel alongside the LUT. A reset clears them, so in-flight lookups are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid_q <= '0;
        end else begin
            tag_valid_q[0] <= issue;
            for (int i = 1; i < LUT_LATENCY; i++) tag_valid_q[i] <= tag_valid_q[i-1];
        end
    end

    // The angle and final-flag payload of each tag has no reset; its valid bit qualifies it.
    always_ff @(posedge clk) begin
        tag_angle_q[0] <= angle_q;
        tag_final_q[0] <= is_final;
        for (int i = 1; i < LUT_LATENCY; i++) begin
            tag_angle_q[i] <= tag_angle_q[i-1];
            tag_final_q[i] <= tag_final_q[i-1];
        end
    end

    // FIFO storage is written when a tagged LUT result arrives.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_angle_q[wr_ptr_q] <= tag_angle_q[LUT_LATENCY-1];
            fifo_part_q[wr_ptr_q]  <= lut_accu_part;
            fifo_base_q[wr_ptr_q]  <= lut_accu_base;
            fifo_last_q[wr_ptr_q]  <= tag_final_q[LUT_LATENCY-1];
        end
    end

    // FIFO pointers and occupancy. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Handshake outputs. The FIFO head is gated to zero while empty, so stale entries never show.
    always_comb begin
        hs_busy      = (state_q == ISSUE) || (state_q == DRAIN);
        hs_done      = (state_q == DONE);
        hs_error     = (state_q == DONE) && error_q;
        lut_angle    = angle_q;
        mp_valid     = (count_q != '0);
        mp_last      = mp_valid && fifo_last_q[rd_ptr_q];
        mp_angle     = mp_valid ? fifo_angle_q[rd_ptr_q] : '0;
        mp_accu_part = mp_valid ? fifo_part_q[rd_ptr_q]  : '0;
        mp_accu_base = mp_valid ? fifo_base_q[rd_ptr_q]  : '0;
    end

endmodule
